fp_mul: RTL and testbench

Pipelined IEEE-754 single-precision (binary32) floating-point multiplier with a fixed latency. It has no handshake: a new operand pair is accepted every clock cycle, and each product appears on `FP_Z` a fixed number of cycles later. It sits in the datapath under test, behind a wrapper that drives `FP_A`/`FP_B` and samples `FP_Z` after the pipeline latency.

---
 rtl/fp_mul.sv | 177 +++++++++++++++++
 tb/tb_fp_mul.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/fp_mul.sv
// Pipelined binary32 multiplier, round-to-nearest-even, denormals-are-zero.
// Define FPMUL_INPUT_REG_EN to register FP_A/FP_B on entry (latency 4 instead of 3).
module fp_mul (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] FP_A,
    input  logic [31:0] FP_B,
    output logic [31:0] FP_Z
);

    localparam logic [31:0] QNAN = 32'h7FC0_0000;

    logic [31:0] w_a;
    logic [31:0] w_b;

`ifdef FPMUL_INPUT_REG_EN
    logic [31:0] r_in_a;
    logic [31:0] r_in_b;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_in_a <= '0;
            r_in_b <= '0;
        end else begin
            r_in_a <= FP_A;
            r_in_b <= FP_B;
        end
    end

    assign w_a = r_in_a;
    assign w_b = r_in_b;
`else
    assign w_a = FP_A;
    assign w_b = FP_B;
`endif

    // ---------------- stage 1: unpack and classify
    logic              w_sa;
    logic              w_sb;
    logic [7:0]        w_ea;
    logic [7:0]        w_eb;
    logic [22:0]       w_fa;
    logic [22:0]       w_fb;
    logic              w_za;
    logic              w_zb;
    logic              w_infa;
    logic              w_infb;
    logic              w_nana;
    logic              w_nanb;
    logic signed [9:0] w_exp1;

    assign w_sa   = w_a[31];
    assign w_sb   = w_b[31];
    assign w_ea   = w_a[30:23];
    assign w_eb   = w_b[30:23];
    assign w_fa   = w_a[22:0];
    assign w_fb   = w_b[22:0];

    // exponent 0 covers both true zero and flushed subnormals
    assign w_za   = (w_ea == 8'h00);
    assign w_zb   = (w_eb == 8'h00);
    assign w_infa = (w_ea == 8'hFF) && (w_fa == 23'd0);
    assign w_infb = (w_eb == 8'hFF) && (w_fb == 23'd0);
    assign w_nana = (w_ea == 8'hFF) && (w_fa != 23'd0);
    assign w_nanb = (w_eb == 8'hFF) && (w_fb != 23'd0);

    assign w_exp1 = $signed({2'b00, w_ea}) + $signed({2'b00, w_eb}) - 10'sd127;

    logic              r_s1_sign;
    logic signed [9:0] r_s1_exp;
    logic [23:0]       r_s1_ma;
    logic [23:0]       r_s1_mb;
    logic              r_s1_nan;
    logic              r_s1_inf;
    logic              r_s1_zero;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_s1_sign <= 1'b0;
            r_s1_exp  <= '0;
            r_s1_ma   <= '0;
            r_s1_mb   <= '0;
            r_s1_nan  <= 1'b0;
            r_s1_inf  <= 1'b0;
            r_s1_zero <= 1'b0;
        end else begin
            r_s1_sign <= w_sa ^ w_sb;
            r_s1_exp  <= w_exp1;
            r_s1_ma   <= {1'b1, w_fa};
            r_s1_mb   <= {1'b1, w_fb};
            r_s1_nan  <= w_nana | w_nanb
                       | (w_infa & w_zb)
                       | (w_infb & w_za);
            r_s1_inf  <= w_infa | w_infb;
            r_s1_zero <= w_za | w_zb;
        end
    end

    // ---------------- stage 2: mantissa multiply
    logic              r_s2_sign;
    logic signed [9:0] r_s2_exp;
    logic [47:0]       r_s2_prod;
    logic              r_s2_nan;
    logic              r_s2_inf;
    logic              r_s2_zero;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_s2_sign <= 1'b0;
            r_s2_exp  <= '0;
            r_s2_prod <= '0;
            r_s2_nan  <= 1'b0;
            r_s2_inf  <= 1'b0;
            r_s2_zero <= 1'b0;
        end else begin
            r_s2_sign <= r_s1_sign;
            r_s2_exp  <= r_s1_exp;
            r_s2_prod <= r_s1_ma * r_s1_mb;
            r_s2_nan  <= r_s1_nan;
            r_s2_inf  <= r_s1_inf;
            r_s2_zero <= r_s1_zero;
        end
    end

    // ---------------- stage 3: normalize, round, pack
    logic              w_top;
    logic [22:0]       w_mant;
    logic              w_guard;
    logic              w_sticky;
    logic              w_inc;
    logic [23:0]       w_rnd;
    logic signed [9:0] w_exp_n;
    logic signed [9:0] w_exp_r;
    logic [22:0]       w_frac;
    logic [31:0]       w_z;

    assign w_top    = r_s2_prod[47];
    assign w_mant   = w_top ? r_s2_prod[46:24] : r_s2_prod[45:23];
    assign w_guard  = w_top ? r_s2_prod[23] : r_s2_prod[22];
    assign w_sticky = w_top ? (|r_s2_prod[22:0]) : (|r_s2_prod[21:0]);
    assign w_exp_n  = w_top ? (r_s2_exp + 10'sd1) : r_s2_exp;

    assign w_inc    = w_guard & (w_sticky | w_mant[0]);
    assign w_rnd    = {1'b0, w_mant} + {23'd0, w_inc};

    // carry out of the 23-bit fraction means the mantissa became 2.0
    assign w_exp_r  = w_rnd[23] ? (w_exp_n + 10'sd1) : w_exp_n;
    assign w_frac   = w_rnd[23] ? 23'd0 : w_rnd[22:0];

    always_comb begin
        w_z = {r_s2_sign, w_exp_r[7:0], w_frac};
        if (r_s2_nan) begin
            w_z = QNAN;
        end else if (r_s2_inf) begin
            w_z = {r_s2_sign, 8'hFF, 23'd0};
        end else if (r_s2_zero) begin
            w_z = {r_s2_sign, 31'd0};
        end else if (w_exp_r >= 10'sd255) begin
            w_z = {r_s2_sign, 8'hFF, 23'd0};
        end else if (w_exp_r <= 10'sd0) begin
            w_z = {r_s2_sign, 31'd0};
        end
    end

    logic [31:0] r_z;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_z <= '0;
        end else begin
            r_z <= w_z;
        end
    end

    assign FP_Z = r_z;

endmodule

// File: tb/tb_fp_mul.sv
// Self-checking bench for fp_mul: directed table, streaming against a
// reference model, and reset with operations in flight.
module tb_fp_mul;

`ifdef FPMUL_INPUT_REG_EN
    localparam int LAT = 4;
`else
    localparam int LAT = 3;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] z;

    int n_total = 0;
    int n_fail  = 0;

    fp_mul dut (
        .clk  (clk),
        .rst  (rst),
        .FP_A (a),
        .FP_B (b),
        .FP_Z (z)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] z;
    } vec_t;

    vec_t tbl[12];

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        n_total++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %08h expected %08h", name, act, exp);
        end
    endtask

    // Reference: exact integer product of the significands, then
    // round-to-nearest-even on the value that falls off the right.
    function automatic logic [31:0] ref_mul(input logic [31:0] x,
                                            input logic [31:0] y);
        logic        s;
        int          ex;
        int          ey;
        int          e;
        int          sh;
        longint      p;
        longint      q;
        longint      rem;
        longint      half;
        logic        zx, zy, ix, iy, nx, ny;
        logic [31:0] r;
        ex = int'(x[30:23]);
        ey = int'(y[30:23]);
        s  = x[31] ^ y[31];
        zx = (ex == 0);
        zy = (ey == 0);
        ix = (ex == 255) && (x[22:0] == 0);
        iy = (ey == 255) && (y[22:0] == 0);
        nx = (ex == 255) && (x[22:0] != 0);
        ny = (ey == 255) && (y[22:0] != 0);
        if (nx || ny || (ix && zy) || (iy && zx)) return 32'h7FC0_0000;
        if (ix || iy) return {s, 8'hFF, 23'd0};
        if (zx || zy) return {s, 31'd0};
        p = (longint'(x[22:0]) + 64'd8388608) * (longint'(y[22:0]) + 64'd8388608);
        e = ex + ey - 127;
        if (p >= (longint'(1) << 47)) begin
            sh = 24;
            e  = e + 1;
        end else begin
            sh = 23;
        end
        q    = p >> sh;
        rem  = p - (q << sh);
        half = longint'(1) << (sh - 1);
        if (rem > half || (rem == half && q[0])) q = q + 1;
        if (q == (longint'(1) << 24)) begin
            q = q >> 1;
            e = e + 1;
        end
        if (e >= 255) return {s, 8'hFF, 23'd0};
        if (e <= 0) return {s, 31'd0};
        r = {s, e[7:0], q[22:0]};
        return r;
    endfunction

    function automatic logic [31:0] rnd_op(input bit normal_only);
        logic [31:0] sp[8];
        logic [7:0]  e;
        sp = '{32'h0000_0000, 32'h8000_0000, 32'h7F80_0000, 32'hFF80_0000,
               32'h7FC0_0000, 32'h7F80_0001, 32'h0000_0001, 32'h807F_FFFF};
        if (normal_only) begin
            e = 8'($urandom_range(100, 154));
            return {1'($urandom), e, 23'($urandom)};
        end
        case ($urandom_range(0, 9))
            0: return sp[$urandom_range(0, 7)];
            1: return $urandom;
            2, 3, 4, 5: begin
                e = 8'($urandom_range(100, 154));
                return {1'($urandom), e, 23'($urandom)};
            end
            default: begin
                e = 8'($urandom_range(1, 254));
                return {1'($urandom), e, 23'($urandom)};
            end
        endcase
    endfunction

    task automatic stream(input int n, input bit normal_only, input string name);
        logic [31:0] exq[$];
        for (int t = 0; t < n + LAT; t++) begin
            @(negedge clk);
            if (t >= LAT) chk(name, z, exq.pop_front());
            if (t < n) begin
                a = rnd_op(normal_only);
                b = rnd_op(normal_only);
                exq.push_back(ref_mul(a, b));
            end
        end
    endtask

    initial begin
        logic [31:0] prev;
        logic [31:0] na;
        logic [31:0] nb;

        tbl[0]  = '{32'h4000_0000, 32'h4040_0000, 32'h40C0_0000};
        tbl[1]  = '{32'h3FC0_0000, 32'h3FC0_0000, 32'h4010_0000};
        tbl[2]  = '{32'hC000_0000, 32'h3F00_0000, 32'hBF80_0000};
        tbl[3]  = '{32'h3F80_0001, 32'h3F80_0001, 32'h3F80_0002};
        tbl[4]  = '{32'h7F80_0000, 32'h0000_0000, 32'h7FC0_0000};
        tbl[5]  = '{32'hFF80_0000, 32'h4000_0000, 32'hFF80_0000};
        tbl[6]  = '{32'h7FC0_0000, 32'h3F80_0000, 32'h7FC0_0000};
        tbl[7]  = '{32'h8000_0000, 32'h4000_0000, 32'h8000_0000};
        tbl[8]  = '{32'h0040_0000, 32'h3F80_0000, 32'h0000_0000};
        tbl[9]  = '{32'h7F7F_FFFF, 32'h4000_0000, 32'h7F80_0000};
        tbl[10] = '{32'h0080_0000, 32'h0080_0000, 32'h0000_0000};
        tbl[11] = '{32'h3F80_0000, 32'hBFC0_0000, 32'hBFC0_0000};

        rst = 1'b0;
        a   = 32'h4000_0000;
        b   = 32'h4040_0000;
        repeat (3) @(negedge clk);
        chk("reset_z", z, 32'h0);

        a = '0;
        b = '0;
        rst = 1'b1;
        repeat (LAT + 1) @(negedge clk);
        chk("idle_zero", z, 32'h0);

        prev = 32'h0;
        foreach (tbl[i]) begin
            a = tbl[i].a;
            b = tbl[i].b;
            repeat (LAT - 1) @(negedge clk);
            chk($sformatf("vec%0d_early", i), z, prev);
            @(negedge clk);
            chk($sformatf("vec%0d", i), z, tbl[i].z);
            prev = tbl[i].z;
        end

        stream(10, 1'b1, "b2b");
        stream(400, 1'b0, "random");

        // three operations in flight, reset between clock edges
        a = 32'h4000_0000; b = 32'h4040_0000;
        @(negedge clk);
        a = 32'h3FC0_0000; b = 32'h3FC0_0000;
        @(negedge clk);
        a = 32'hC000_0000; b = 32'h3F00_0000;
        @(posedge clk);
        #2;
        rst = 1'b0;
        #1;
        chk("midreset_z", z, 32'h0);
        repeat (2) @(negedge clk);
        chk("midreset_hold", z, 32'h0);

        na = 32'h4040_0000;
        nb = 32'h4080_0000;
        a   = na;
        b   = nb;
        rst = 1'b1;
        for (int k = 1; k < LAT; k++) begin
            @(negedge clk);
            chk($sformatf("post_reset_c%0d", k), z, 32'h0);
        end
        @(negedge clk);
        chk("post_reset_first", z, ref_mul(na, nb));
        chk("post_reset_const", ref_mul(na, nb), 32'h4140_0000);
        repeat (3) @(negedge clk);
        chk("hold_const", z, 32'h4140_0000);

        $display("%0d/%0d checks passed", n_total - n_fail, n_total);
        $finish;
    end

endmodule
